// File: rtl/byte_stream_sequencer.sv
// byte_stream_sequencer: splits 32-bit words into a valid/ready byte stream with a one-word pending buffer
module byte_stream_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [2:0]       in_len,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             err_pulse,
  output logic [CNT_W-1:0] words_done
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t      state;
  logic [31:0] cur_data, pend_data;
  logic [2:0]  cur_len, pend_len, len_c;
  logic        cur_lsb, pend_lsb, pend_valid;
  logic [1:0]  k, lane;
  logic        acc, acc_ok, hs, fin;
  assign in_ready  = !pend_valid;
  assign acc       = in_valid && in_ready;
  assign acc_ok    = acc && in_len != 3'd0;
  assign len_c     = in_len > 3'd4 ? 3'd4 : in_len;
  assign out_valid = state == SEND;
  assign hs        = out_valid && out_ready;
  // lsb-first walks lanes 3..0, i.e. the bitwise inverse of k
  assign lane      = cur_lsb ? ~k : k;
  assign out_idx   = lane;
  assign out_byte  = cur_data[{~lane, 3'b000} +: 8];
  assign out_last  = out_valid && ({1'b0, k} == cur_len - 3'd1);
  assign fin       = hs && out_last;
  assign busy      = out_valid || pend_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_data   <= '0;
      cur_len    <= '0;
      cur_lsb    <= 1'b0;
      k          <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_len   <= '0;
      pend_lsb   <= 1'b0;
      err_pulse  <= 1'b0;
      words_done <= '0;
    end else begin
      err_pulse <= acc && in_len == 3'd0;
      if (fin) begin
        words_done <= words_done + 1'b1;
        k          <= '0;
        if (pend_valid) begin
          {cur_data, cur_len, cur_lsb}    <= {pend_data, pend_len, pend_lsb};
          {pend_data, pend_len, pend_lsb} <= '0;
          pend_valid                      <= 1'b0;
        end else if (acc_ok) begin
          {cur_data, cur_len, cur_lsb} <= {in_data, len_c, in_lsb_first};
        end else begin
          {cur_data, cur_len, cur_lsb} <= '0;
          state                        <= IDLE;
        end
      end else if (hs) begin
        k <= k + 2'd1;
      end
      if (acc_ok && !fin) begin
        if (state == IDLE) begin
          {cur_data, cur_len, cur_lsb} <= {in_data, len_c, in_lsb_first};
          k                            <= '0;
          state                        <= SEND;
        end else begin
          {pend_data, pend_len, pend_lsb} <= {in_data, len_c, in_lsb_first};
          pend_valid                      <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_byte_stream_sequencer.sv
// tb_byte_stream_sequencer: directed stimulus checked against a byte-queue model plus literal expectations
module tb_byte_stream_sequencer;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_lsb_first = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic [2:0]  in_len = 0;
  logic        in_ready, out_valid, out_last, busy, err_pulse;
  logic [7:0]  out_byte;
  logic [1:0]  out_idx;
  logic [15:0] words_done;
  int checks = 0, errors = 0;

  byte_stream_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_len(in_len), .in_lsb_first(in_lsb_first), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .err_pulse(err_pulse), .words_done(words_done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] b; logic [1:0] idx; logic last;} ent_t;
  ent_t        q[$];
  ent_t        e;
  int          held = 0, n;
  logic [15:0] m_done = 0;
  logic        m_err = 0, m_acc, m_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: words expand into a flat queue of bytes; a word is held until its last byte leaves
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      held = 0;
      m_done = 0;
      m_err = 0;
    end else begin
      m_acc = in_valid && held < 2;
      m_hs  = q.size() > 0 && out_ready;
      if (m_hs) begin
        e = q.pop_front();
        if (e.last) begin
          held--;
          m_done++;
        end
      end
      m_err = m_acc && in_len == 0;
      if (m_acc && in_len != 0) begin
        n = in_len > 4 ? 4 : int'(in_len);
        for (int i = 0; i < n; i++) begin
          e.idx  = in_lsb_first ? 2'(3 - i) : 2'(i);
          e.b    = in_data[8*(3-int'(e.idx)) +: 8];
          e.last = (i == n - 1);
          q.push_back(e);
        end
        held++;
      end
    end
  end

  always @(negedge clk) if (!reset) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, held < 2);
    chk("busy", busy, held > 0);
    chk("err_pulse", err_pulse, m_err);
    chk("words_done", words_done, m_done);
    if (q.size() > 0) begin
      chk("out_byte", out_byte, q[0].b);
      chk("out_idx", out_idx, q[0].idx);
      chk("out_last", out_last, q[0].last);
    end
  end

  task automatic put(input logic [31:0] d, input logic [2:0] l, input logic lsb);
    int t = 0;
    in_valid = 1; in_data = d; in_len = l; in_lsb_first = lsb;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("accept_timeout", 1, 0);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_neg(input int c);
    repeat (c) @(negedge clk);
  endtask

  logic [7:0] seq[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};

  initial begin
    wait_neg(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_words_done", words_done, 0);
    reset = 0;
    out_ready = 1;
    put(32'h12345678, 3'd4, 1'b0);
    chk("t1_first_byte", out_byte, 8'h12);
    chk("t1_first_idx", out_idx, 0);
    wait_neg(3);
    chk("t1_fourth_byte", out_byte, 8'h78);
    chk("t1_fourth_last", out_last, 1);
    wait_neg(1);
    chk("t1_done", words_done, 1);
    put(32'h12345678, 3'd2, 1'b1);
    chk("t2_byte0", out_byte, 8'h78);
    chk("t2_idx0", out_idx, 3);
    wait_neg(1);
    chk("t2_byte1", out_byte, 8'h56);
    chk("t2_last1", out_last, 1);
    put(32'hAABBCCDD, 3'd7, 1'b0);
    chk("t2_clamp_byte0", out_byte, 8'hAA);
    wait_neg(3);
    chk("t2_clamp_byte3", out_byte, 8'hDD);
    chk("t2_clamp_last", out_last, 1);
    wait_neg(1);
    chk("t2_done", words_done, 3);
    in_valid = 1; in_data = 32'h01020304; in_len = 4; in_lsb_first = 0;
    wait_neg(1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_stream_valid", out_valid, 1);
      chk("t3_stream_byte", out_byte, seq[i]);
      if (i == 0) in_data = 32'hA0B0C0D0;
      if (i == 1) in_valid = 0;
      wait_neg(1);
    end
    chk("t3_done", words_done, 5);
    put(32'h12345678, 3'd4, 1'b0);
    wait_neg(1);
    chk("t4_byte", out_byte, 8'h34);
    out_ready = 0;
    in_valid = 1; in_data = 32'h55667788; in_len = 4; in_lsb_first = 0;
    wait_neg(1);
    in_data = 32'h99AABBCC;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_byte", out_byte, 8'h34);
      chk("t4_hold_idx", out_idx, 1);
      chk("t4_pend_ready", in_ready, 0);
      if (i < 2) wait_neg(1);
    end
    out_ready = 1;
    put(32'h99AABBCC, 3'd4, 1'b0);
    wait_neg(20);
    chk("t4_done", words_done, 8);
    put(32'hDEADBEEF, 3'd0, 1'b0);
    chk("t5_err", err_pulse, 1);
    chk("t5_no_valid", out_valid, 0);
    wait_neg(1);
    chk("t5_err_clear", err_pulse, 0);
    chk("t5_done", words_done, 8);
    put(32'h11223344, 3'd4, 1'b0);
    chk("t6_byte0", out_byte, 8'h11);
    in_valid = 1; in_data = 32'h55555555;
    wait_neg(1);
    in_valid = 0;
    chk("t6_byte1", out_byte, 8'h22);
    chk("t6_pending", in_ready, 0);
    @(posedge clk);
    #1 reset = 1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_done", words_done, 0);
    wait_neg(1);
    reset = 0;
    put(32'hCAFEF00D, 3'd4, 1'b0);
    chk("t6_new_byte", out_byte, 8'hCA);
    chk("t6_new_idx", out_idx, 0);
    wait_neg(6);
    chk("t6_new_done", words_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_stream_sequencer.md
Name: byte_stream_sequencer

Overview:
- Sequences the 32-bit word splitter datapath. Accepts words on a valid/ready input port and emits their bytes one per cycle on a valid/ready output port.
- Byte lanes follow the splitter mapping: O1=A[31:24], O2=A[23:16], O3=A[15:8], O4=A[7:0].
- A one-entry pending buffer lets back-to-back words stream without a bubble.
- Sits between a word producer (e.g. memory read path) and a byte-wide consumer.

Parameters:
- CNT_W, 16, width of the completed-word counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  producer offers a word
- in_ready  output  1  block can accept a word this cycle
- in_data  input  32  word to split
- in_len  input  3  byte count to emit: 1..4; 0 = invalid; 5..7 clamp to 4
- in_lsb_first  input  1  0: O1,O2,O3,O4 order; 1: O4,O3,O2,O1 order
- out_valid  output  1  out_byte is valid
- out_ready  input  1  consumer takes the byte
- out_byte  output  8  current byte
- out_idx  output  2  lane index of out_byte (0=O1 .. 3=O4)
- out_last  output  1  out_byte is the final byte of its word
- busy  output  1  current word or pending word is held
- err_pulse  output  1  one-cycle pulse when an in_len=0 word is accepted
- words_done  output  CNT_W  count of words fully emitted

Behaviour:
- Reset values: all outputs 0 except in_ready=1. cur and pend registers cleared, state IDLE.
- Reset asserted mid-word discards cur and pend immediately. No further bytes are emitted for either.
- Storage:
  - cur holds data, len, order and byte counter k (0..len-1).
  - pend holds one queued word.
  - in_ready = !pend_valid (registered state only; no combinational path from out_ready).
  - Input handshake = in_valid && in_ready. Output handshake = out_valid && out_ready.
- States:
  - IDLE: cur empty.
  - SEND: cur valid, out_valid=1.
  - IDLE->SEND on an accepted word with len!=0. Latency is 1 cycle: accept at edge T, out_valid high after edge T.
  - SEND->IDLE on handshake of the last byte when pend is empty and no word is accepted that cycle.
- Lane selection:
  - msb-first: lane = k.
  - lsb-first: lane = 3-k.
  - out_byte = lane byte of cur data; out_idx = lane; out_last = (k == len-1).
- Byte advance: on an output handshake with k < len-1, k increments.
- Last-byte handshake, same edge, in priority order:
  - pend valid: cur <= pend, k <= 0. Any accepted input word goes into pend.
  - pend empty and a word is accepted: cur <= accepted word.
  - Otherwise: cur cleared.
  - words_done increments on every last-byte handshake and wraps at 2^CNT_W.
- Accept with cur empty: word goes to cur. Accept while cur is busy and not finishing: word goes to pend.
- No bubble: a continuous stream with out_ready=1 keeps out_valid high across word boundaries.
- Stability: while out_valid && !out_ready, out_byte, out_idx and out_last hold constant.
- in_len=0:
  - Word is accepted (in_ready rules unchanged) but never stored.
  - err_pulse=1 for the cycle after acceptance.
  - Counters and state are unaffected.
- in_len 5..7 are stored as 4.
- busy = cur_valid || pend_valid.

Test Plan:
- Reset, then in_data=0x12345678, len=4, msb-first, out_ready=1 -> bytes 0x12,0x34,0x56,0x78 on four consecutive cycles starting 1 cycle after accept; out_idx 0,1,2,3; out_last only on 0x78; words_done=1.
- in_data=0x12345678, len=2, lsb-first -> bytes 0x78,0x56; out_idx 3,2; out_last on 0x56. Then len=7 msb-first on 0xAABBCCDD -> 4 bytes AA,BB,CC,DD.
- Back-to-back words 0x01020304 and 0xA0B0C0D0 (len 4, msb-first) with out_ready=1 -> 8 consecutive valid cycles (01,02,03,04,A0,B0,C0,D0) with no bubble; words_done=2.
- Backpressure: drop out_ready for 3 cycles while 0x34 is presented -> 0x34, idx 1 held stable. Present a second and third word -> second lands in pend, in_ready=0, third stalls until cur finishes.
- in_len=0 with in_data=0xDEADBEEF -> accepted, err_pulse high exactly 1 cycle, out_valid stays 0, words_done unchanged.
- Assert reset asynchronously after the second byte of 0x11223344 with a word pending -> out_valid=0, busy=0, in_ready=1, words_done=0 immediately. After release, a new word emits normally starting at lane 0.
